// File: rtl/bist_controller.sv
//------------------------------------------------------------------------------
// bist_controller
//
// Sequences one complete logic-BIST session around a TPG / CUT-mux / SISR
// datapath:
//   IDLE -> INIT (seed LFSR, clear SISR) -> RUN (NUM_PATTERNS patterns)
//        -> FLUSH (FLUSH_CYCLES SISR-only cycles) -> COMPARE -> DONE
//
// The CUT input mux select (bist_mode) is low whenever no session is in
// flight, so the CUT sees its functional inputs in IDLE and DONE.
//
// Parameters
//   NUM_PATTERNS : patterns applied per session, 1 .. 2^CNT_W-1
//   CNT_W        : width of the pattern counter
//   FLUSH_CYCLES : SISR-only cycles after the last pattern, >= 1
//   GOLDEN_SIG   : expected fault-free 4-bit signature
//
// Ports
//   clk           in   single clock, rising-edge active
//   reset_n       in   asynchronous active-low reset
//   start         in   level-sampled session request (ignored while busy)
//   abort         in   synchronous abandon; wins over start
//   signature     in   current SISR contents
//   bist_mode     out  CUT mux select (1 = TPG patterns, 0 = functional)
//   lfsr_load     out  one-cycle TPG seed load (INIT only)
//   lfsr_en       out  TPG advance enable (RUN only)
//   sisr_clr      out  one-cycle SISR clear (INIT only)
//   sisr_en       out  SISR shift enable (RUN and FLUSH)
//   busy          out  session in flight (INIT, RUN, FLUSH, COMPARE)
//   done          out  session finished, result valid (DONE)
//   pass          out  registered result: signature == GOLDEN_SIG
//   fail          out  registered result: signature != GOLDEN_SIG
//   pattern_count out  patterns applied so far in this session
//------------------------------------------------------------------------------
module bist_controller #(
    parameter int unsigned NUM_PATTERNS = 15,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [3:0]  GOLDEN_SIG   = 4'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       signature,
    output logic             bist_mode,
    output logic             lfsr_load,
    output logic             lfsr_en,
    output logic             sisr_clr,
    output logic             sisr_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] pattern_count
);

    //--------------------------------------------------------------------------
    // State encoding
    //--------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INIT    = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_FLUSH   = 3'd3;
    localparam logic [2:0] ST_COMPARE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // The flush counter only has to reach FLUSH_CYCLES-1.
    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam longint unsigned LP_CNT_MAX = (longint'(1) << CNT_W) - 1;

    localparam logic [CNT_W-1:0] LP_LAST_PAT   = CNT_W'(NUM_PATTERNS - 1);
    localparam logic [FC_W-1:0]  LP_LAST_FLUSH = FC_W'(FLUSH_CYCLES - 1);

    //--------------------------------------------------------------------------
    // Elaboration-time parameter checks. RUN leaves on the count that equals
    // NUM_PATTERNS-1, so the counter tops out at NUM_PATTERNS and can never
    // wrap as long as NUM_PATTERNS fits in CNT_W bits.
    //--------------------------------------------------------------------------
    if (NUM_PATTERNS < 1 || longint'(NUM_PATTERNS) > LP_CNT_MAX) begin : g_bad_num_patterns
        $error("bist_controller: NUM_PATTERNS must be in 1 .. 2^CNT_W-1");
    end

    if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
        $error("bist_controller: FLUSH_CYCLES must be >= 1");
    end

    //--------------------------------------------------------------------------
    // Registers and wires
    //--------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_pattern_count;
    logic [FC_W-1:0]  r_flush_cnt;
    logic             r_pass;
    logic             r_fail;
    logic             r_bist_mode;
    logic             r_lfsr_load;
    logic             r_lfsr_en;
    logic             r_sisr_clr;
    logic             r_sisr_en;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_state_nxt;
    logic             w_last_pat;
    logic             w_last_flush;
    logic             w_sig_match;
    logic             w_enter_init;

    assign w_last_pat   = (r_pattern_count == LP_LAST_PAT);
    assign w_last_flush = (r_flush_cnt == LP_LAST_FLUSH);
    assign w_sig_match  = (signature == GOLDEN_SIG);
    // abort forces IDLE in the next-state logic, so this is never set together
    // with abort.
    assign w_enter_init = (w_state_nxt == ST_INIT);

    //--------------------------------------------------------------------------
    // Next-state logic. abort overrides everything, including a simultaneous
    // start. start is only looked at in IDLE and DONE, so holding it high
    // during a session has no effect.
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_INIT;
                    end
                end
                ST_INIT: begin
                    w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (w_last_pat) begin
                        w_state_nxt = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_last_flush) begin
                        w_state_nxt = ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    w_state_nxt = ST_DONE;
                end
                ST_DONE: begin
                    if (start) begin
                        w_state_nxt = ST_INIT;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // State, counters and result flags
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_pattern_count <= '0;
            r_flush_cnt     <= '0;
            r_pass          <= 1'b0;
            r_fail          <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Cleared on the edge into INIT so the INIT cycle already shows 0;
            // afterwards one increment per RUN cycle.
            if (abort || w_enter_init) begin
                r_pattern_count <= '0;
            end else if (r_state == ST_RUN) begin
                r_pattern_count <= r_pattern_count + CNT_W'(1);
            end

            // Counts FLUSH cycles; sits at 0 outside FLUSH so every session
            // starts its flush from a clean value.
            if (r_state == ST_FLUSH && !abort && !w_last_flush) begin
                r_flush_cnt <= r_flush_cnt + FC_W'(1);
            end else begin
                r_flush_cnt <= '0;
            end

            // Signature is sampled at the end of the COMPARE cycle, after the
            // flush has pushed the last response into the SISR.
            if (abort || w_enter_init) begin
                r_pass <= 1'b0;
                r_fail <= 1'b0;
            end else if (r_state == ST_COMPARE) begin
                r_pass <= w_sig_match;
                r_fail <= !w_sig_match;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Datapath strobes, registered from the next state so they line up with
    // the state register and reach the TPG/SISR glitch-free.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bist_mode <= 1'b0;
            r_lfsr_load <= 1'b0;
            r_lfsr_en   <= 1'b0;
            r_sisr_clr  <= 1'b0;
            r_sisr_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_bist_mode <= 1'b0;
            r_lfsr_load <= 1'b0;
            r_lfsr_en   <= 1'b0;
            r_sisr_clr  <= 1'b0;
            r_sisr_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            case (w_state_nxt)
                ST_INIT: begin
                    r_bist_mode <= 1'b1;
                    r_lfsr_load <= 1'b1;
                    r_sisr_clr  <= 1'b1;
                    r_busy      <= 1'b1;
                end
                ST_RUN: begin
                    r_bist_mode <= 1'b1;
                    r_lfsr_en   <= 1'b1;
                    r_sisr_en   <= 1'b1;
                    r_busy      <= 1'b1;
                end
                ST_FLUSH: begin
                    r_bist_mode <= 1'b1;
                    r_sisr_en   <= 1'b1;
                    r_busy      <= 1'b1;
                end
                ST_COMPARE: begin
                    r_bist_mode <= 1'b1;
                    r_busy      <= 1'b1;
                end
                ST_DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_bist_mode <= 1'b0;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign bist_mode     = r_bist_mode;
    assign lfsr_load     = r_lfsr_load;
    assign lfsr_en       = r_lfsr_en;
    assign sisr_clr      = r_sisr_clr;
    assign sisr_en       = r_sisr_en;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign fail          = r_fail;
    assign pattern_count = r_pattern_count;

endmodule

// File: tb/tb_bist_controller.sv
//------------------------------------------------------------------------------
// tb_bist_controller
//
// Two instances share all inputs: A uses the default parameters, B uses
// NUM_PATTERNS = 1, FLUSH_CYCLES = 3. Every cycle both are compared against a
// reference model that tracks only "cycles since the session started" and
// derives each output from the session time line arithmetically.
//------------------------------------------------------------------------------
module tb_bist_controller;

    localparam int NA = 15;
    localparam int FA = 1;
    localparam int NB = 1;
    localparam int FB = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [3:0] signature;

    logic       a_bm, a_ld, a_len, a_clr, a_sen, a_busy, a_done, a_pass, a_fail;
    logic [7:0] a_cnt;
    logic       b_bm, b_ld, b_len, b_clr, b_sen, b_busy, b_done, b_pass, b_fail;
    logic [7:0] b_cnt;

    logic [16:0] vec_a;
    logic [16:0] vec_b;

    // Vector layout: {bist_mode, lfsr_load, lfsr_en, sisr_clr, sisr_en,
    //                 busy, done, pass, fail, pattern_count[7:0]}
    assign vec_a = {a_bm, a_ld, a_len, a_clr, a_sen, a_busy, a_done, a_pass, a_fail, a_cnt};
    assign vec_b = {b_bm, b_ld, b_len, b_clr, b_sen, b_busy, b_done, b_pass, b_fail, b_cnt};

    always #5 clk = ~clk;

    bist_controller dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .signature(signature),
        .bist_mode(a_bm), .lfsr_load(a_ld), .lfsr_en(a_len), .sisr_clr(a_clr),
        .sisr_en(a_sen), .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail),
        .pattern_count(a_cnt)
    );

    bist_controller #(.NUM_PATTERNS(NB), .CNT_W(8), .FLUSH_CYCLES(FB), .GOLDEN_SIG(4'h0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .signature(signature),
        .bist_mode(b_bm), .lfsr_load(b_ld), .lfsr_en(b_len), .sisr_clr(b_clr),
        .sisr_en(b_sen), .busy(b_busy), .done(b_done), .pass(b_pass), .fail(b_fail),
        .pattern_count(b_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: t = -1 when no session exists, otherwise cycles since INIT
    // (t = 0 is INIT). Result flags kept separately.
    int ta, tb;
    bit pa, fa, pb, fb;

    function automatic logic [16:0] model_vec(input int t, input int n, input int f,
                                              input bit p, input bit fl);
        logic busy_m;
        logic done_m;
        int   cnt;
        busy_m = (t >= 0) && (t <= n + f + 1);
        done_m = (t > n + f + 1);
        if (t <= 0)      cnt = 0;
        else if (t <= n) cnt = t - 1;
        else             cnt = n;
        return {busy_m, (t == 0), (t >= 1 && t <= n), (t == 0), (t >= 1 && t <= n + f),
                busy_m, done_m, p, fl, 8'(cnt)};
    endfunction

    task automatic model_edge(input int n, input int f, inout int t, inout bit p, inout bit fl);
        if (!reset_n) begin
            t = -1; p = 0; fl = 0;
        end else if (abort) begin
            t = -1; p = 0; fl = 0;
        end else if (t < 0 || t > n + f + 1) begin
            if (start) begin
                t = 0; p = 0; fl = 0;
            end
        end else begin
            if (t == n + f + 1) begin
                p  = (signature == 4'h0);
                fl = !p;
            end
            t = t + 1;
        end
    endtask

    task automatic check_vec(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(NA, FA, ta, pa, fa);
        model_edge(NB, FB, tb, pb, fb);
        #1;
        check_vec("model_a", vec_a, model_vec(ta, NA, FA, pa, fa));
        check_vec("model_b", vec_b, model_vec(tb, NB, FB, pb, fb));
    endtask

    // Asserts reset between edges and checks the asynchronous effect at once.
    // Leaves reset_n low; the caller releases it.
    task automatic async_reset(input string name);
        #2;
        reset_n = 1'b0;
        ta = -1; pa = 0; fa = 0;
        tb = -1; pb = 0; fb = 0;
        #1;
        check_vec({name, "_a"}, vec_a, 17'h0);
        check_vec({name, "_b"}, vec_b, 17'h0);
    endtask

    // One start pulse, then run until done on instance A, tallying strobes.
    task automatic run_session(output int n_load, output int n_len, output int n_sen,
                               output int done_cyc, output int first_ok);
        n_load = 0; n_len = 0; n_sen = 0; done_cyc = -1;
        start = 1'b1;
        step();
        first_ok = (a_ld && a_clr && a_bm && !a_pass && !a_fail && !a_done && a_cnt == 8'd0) ? 1 : 0;
        n_load += int'(a_ld); n_len += int'(a_len); n_sen += int'(a_sen);
        start = 1'b0;
        for (int e = 1; e < 60 && done_cyc < 0; e++) begin
            step();
            n_load += int'(a_ld); n_len += int'(a_len); n_sen += int'(a_sen);
            if (a_done) done_cyc = e + 1;
        end
    endtask

    typedef struct {
        logic        start;
        logic        abort;
        logic [3:0]  sig;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic s, input logic a, input logic [3:0] sg,
                                input logic [8:0] flags, input logic [7:0] cnt);
        vec_t v;
        v.start = s; v.abort = a; v.sig = sg; v.exp = {flags, cnt};
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int l1, e1, s1, d1, f1;
        int l2, e2, s2, d2, f2;
        logic [8:0] F_IDLE, F_INIT, F_RUN, F_FLUSH, F_CMP, F_DPASS, F_DFAIL;

        // {bm, ld, len, clr, sen, busy, done, pass, fail}
        F_IDLE  = 9'b000000000;
        F_INIT  = 9'b110101000;
        F_RUN   = 9'b101011000;
        F_FLUSH = 9'b100011000;
        F_CMP   = 9'b100001000;
        F_DPASS = 9'b000000110;
        F_DFAIL = 9'b000000101;

        // Hand-derived time line for instance B (1 pattern, 3 flush cycles).
        tbl[0]  = mk(1, 0, 4'h0, F_INIT,  8'd0);
        tbl[1]  = mk(0, 0, 4'h0, F_RUN,   8'd0);
        tbl[2]  = mk(0, 0, 4'h0, F_FLUSH, 8'd1);
        tbl[3]  = mk(0, 0, 4'h0, F_FLUSH, 8'd1);
        tbl[4]  = mk(0, 0, 4'h0, F_FLUSH, 8'd1);
        tbl[5]  = mk(0, 0, 4'h0, F_CMP,   8'd1);
        tbl[6]  = mk(0, 0, 4'h0, F_DPASS, 8'd1);
        tbl[7]  = mk(0, 0, 4'h0, F_DPASS, 8'd1);
        tbl[8]  = mk(1, 0, 4'h0, F_INIT,  8'd0);
        tbl[9]  = mk(1, 1, 4'h0, F_IDLE,  8'd0);
        tbl[10] = mk(1, 1, 4'h0, F_IDLE,  8'd0);
        tbl[11] = mk(1, 0, 4'h0, F_INIT,  8'd0);
        tbl[12] = mk(1, 0, 4'h0, F_RUN,   8'd0);
        tbl[13] = mk(1, 0, 4'h0, F_FLUSH, 8'd1);
        tbl[14] = mk(0, 0, 4'hA, F_FLUSH, 8'd1);
        tbl[15] = mk(0, 0, 4'hA, F_FLUSH, 8'd1);
        tbl[16] = mk(0, 0, 4'hA, F_CMP,   8'd1);
        tbl[17] = mk(0, 0, 4'hA, F_DFAIL, 8'd1);

        reset_n = 1'b1; start = 1'b0; abort = 1'b0; signature = 4'h0;
        ta = -1; tb = -1; pa = 0; fa = 0; pb = 0; fb = 0;
        #1 reset_n = 1'b0;
        #1;
        check_vec("reset_a", vec_a, 17'h0);
        check_vec("reset_b", vec_b, 17'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Table-driven time line for instance B
        for (int i = 0; i < 18; i++) begin
            start = tbl[i].start; abort = tbl[i].abort; signature = tbl[i].sig;
            step();
            check_vec($sformatf("tbl_b[%0d]", i), vec_b, tbl[i].exp);
        end
        start = 1'b0; abort = 1'b0; signature = 4'h0;

        // Reset in the middle of RUN on instance A at pattern_count 7
        for (int k = 0; k < 20 && a_cnt != 8'd7; k++) step();
        check_int("reach_cnt7", int'(a_cnt), 7);
        async_reset("rst_mid_run");
        step();
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_int("idle_after_rst", int'(a_busy) + int'(a_bm) + int'(a_done), 0);
        end

        // Nominal pass session, then a second one started from DONE
        run_session(l1, e1, s1, d1, f1);
        check_int("s1_load_cycles", l1, 1);
        check_int("s1_lfsr_en_cycles", e1, 15);
        check_int("s1_sisr_en_cycles", s1, 16);
        check_int("s1_done_cycle", d1, 19);
        check_int("s1_pass", int'(a_pass), 1);
        check_int("s1_fail", int'(a_fail), 0);
        check_int("s1_count", int'(a_cnt), 15);
        check_int("s1_init_clean", f1, 1);
        step();
        check_int("done_hold", int'(a_done), 1);

        run_session(l2, e2, s2, d2, f2);
        check_int("s2_init_from_done", f2, 1);
        check_int("s2_load_same", l2, l1);
        check_int("s2_lfsr_en_same", e2, e1);
        check_int("s2_sisr_en_same", s2, s1);
        check_int("s2_done_same", d2, d1);
        check_int("s2_pass", int'(a_pass), 1);

        // Nominal fail: signature differs from the golden value
        signature = 4'hA;
        run_session(l2, e2, s2, d2, f2);
        check_int("fail_done_cycle", d2, 19);
        check_int("fail_flag", int'(a_fail), 1);
        check_int("fail_pass_flag", int'(a_pass), 0);
        signature = 4'h0;

        // start held through RUN does not restart the session
        start = 1'b1;
        for (int k = 0; k < 11; k++) step();
        check_int("held_start_count", int'(a_cnt), 9);
        check_int("held_start_no_load", int'(a_ld), 0);
        start = 1'b0;
        for (int k = 0; k < 30 && !a_done; k++) step();
        check_int("held_start_done", int'(a_done), 1);

        // abort during FLUSH
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 40 && !(a_bm && a_sen && !a_len); k++) step();
        check_int("reach_flush", int'(a_bm && a_sen && !a_len), 1);
        abort = 1'b1;
        step();
        check_vec("abort_flush", vec_a, 17'h0);
        abort = 1'b0;
        step();
        check_int("abort_no_init", int'(a_ld) + int'(a_busy), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            signature = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rst_rand");
                #1 reset_n = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
